integ_threshold_monitor: RTL and testbench
==========================================

Name: integ_threshold_monitor

Overview:
- SPI-domain consumer of the synchronized, stable configuration outputs: integ_en, integ_window and integ_thresh_avg.
- Accumulates the absolute value of every DAC sample word over a window of integ_window samples.
- Latches a sticky over-threshold fault if the window average exceeds integ_thresh_avg.
- Divider-free: compares the running sum against thresh*window, computed once when the monitor arms.

Parameters:
- SAMPLE_WIDTH, 16: signed two's-complement sample width.
- ACC_WIDTH, 48: accumulator and limit width; must be >= 47.

Ports:
- spi_clk  in  1  SPI-domain clock.
- spi_rst  in  1  asynchronous, active-high reset.
- integ_en  in  1  stable enable from config sync.
- integ_window  in  32  window length in samples; stable.
- integ_thresh_avg  in  15  per-sample average threshold, unsigned; stable.
- sample  in  SAMPLE_WIDTH  DAC sample word, signed.
- sample_valid  in  1  one-cycle qualifier for sample.
- running  out  1  high in ARM or RUN.
- window_done  out  1  one-cycle pulse when a window completes without fault.
- over_thresh  out  1  sticky fault flag.
- cfg_err  out  1  sticky; integ_en was seen with integ_window==0.
- fault_sum  out  ACC_WIDTH  accumulator value that tripped the fault.
- fault_count  out  32  sample index within the window (1-based) that tripped the fault.

Behaviour:
- Reset: asynchronous; all registers clear immediately. State=IDLE; running=0, window_done=0, over_thresh=0, cfg_err=0, fault_sum=0, fault_count=0; accumulator, counter and limit = 0.
- States: IDLE, ARM, RUN, FAULT.
- IDLE:
  - integ_en=1 and integ_window==0 -> FAULT with cfg_err=1; over_thresh stays 0.
  - integ_en=1 and integ_window!=0 -> ARM; latch win=integ_window and limit=integ_thresh_avg*integ_window (47-bit unsigned product, zero-extended to ACC_WIDTH).
- ARM: exactly one cycle; clear acc and cnt; -> RUN. sample_valid in IDLE or ARM is ignored.
- RUN, each sample_valid:
  - abs = |sample| as unsigned SAMPLE_WIDTH; -32768 -> 32768.
  - acc_n = acc + abs; cnt_n = cnt + 1.
  - If acc_n > limit: -> FAULT; next cycle over_thresh=1, fault_sum=acc_n, fault_count=cnt_n. This is the early trip, valid because abs >= 0. It takes priority over window completion on the same sample.
  - Else if cnt_n == win: window_done=1 for one cycle; acc=0; cnt=0; stay in RUN.
  - Else: acc=acc_n; cnt=cnt_n.
- Comparison is strictly greater: average exactly equal to the threshold does not fault.
- Threshold 0: any non-zero sample faults.
- integ_en=0 in RUN or ARM: -> IDLE next cycle; clear acc and cnt; no flag change. A sample_valid on that same cycle is discarded.
- Config inputs that change during RUN are ignored until the next IDLE->ARM.
- FAULT: terminal. Flags hold, running=0, samples are ignored, integ_en is ignored. Only spi_rst exits FAULT.
- Overflow: acc cannot overflow because the trip occurs before acc exceeds limit+2^16 < 2^48. No saturation logic is required.
- Latency: sample_valid -> window_done/over_thresh is 1 cycle. integ_en rise -> first accepted sample is 2 cycles (IDLE->ARM->RUN).

Test Plan:
- Reset/arm: assert spi_rst mid-RUN -> all outputs 0 immediately. Release, then integ_en=1, window=4, thresh=100 -> running=1 two cycles later, first sample accepted in RUN.
- Pass window: window=4, thresh=100, samples 100,-100,100,-100 -> window_done pulses once after the 4th sample, over_thresh=0. Repeat 3 windows -> 3 pulses.
- Early trip: window=4, thresh=100 (limit 400), samples 300,-150 -> over_thresh=1 one cycle after the 2nd sample, fault_sum=450, fault_count=2; further samples ignored; integ_en toggling ignored.
- Boundaries:
  - window=1, thresh=0, sample 0 -> window_done, no fault; sample 1 -> fault.
  - sample=-32768, thresh=32767, window=1 -> fault_sum=32768.
  - window=0 -> cfg_err=1, over_thresh=0.
- Disable mid-window: window=8, 3 samples of 50, then integ_en=0 with a simultaneous sample -> IDLE, acc cleared. Re-enable with thresh changed -> new limit is used and the first window starts from count 0.
- Config change in RUN: change thresh from 100 to 1 mid-window -> no fault with samples of 100; the old limit still applies.

Source files
------------

// File: rtl/integ_threshold_monitor.sv
// integ_threshold_monitor
// Integrates |sample| over a window of integ_window samples and latches a
// sticky fault when the window average would exceed integ_thresh_avg.
// The average test is done without a divider: the running sum is compared
// against thresh*window, computed once when the monitor arms.
module integ_threshold_monitor #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ACC_WIDTH    = 48
) (
    input  logic                           spi_clk,
    input  logic                           spi_rst,
    input  logic                           integ_en,
    input  logic [31:0]                    integ_window,
    input  logic [14:0]                    integ_thresh_avg,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    input  logic                           sample_valid,
    output logic                           running,
    output logic                           window_done,
    output logic                           over_thresh,
    output logic                           cfg_err,
    output logic [ACC_WIDTH-1:0]           fault_sum,
    output logic [31:0]                    fault_count
);

    localparam int PROD_WIDTH = 47;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]              state;
    logic [31:0]             win;
    logic [31:0]             cnt;
    logic [ACC_WIDTH-1:0]    acc;
    logic [ACC_WIDTH-1:0]    limit;

    logic [SAMPLE_WIDTH-1:0] sample_u;
    logic [SAMPLE_WIDTH-1:0] abs_val;
    logic [ACC_WIDTH-1:0]    acc_n;
    logic [31:0]             cnt_n;
    logic [PROD_WIDTH-1:0]   limit_prod;

    // Magnitude of the current sample, next accumulator/count and the arm-time limit.
    // The most negative sample maps to 2^(SAMPLE_WIDTH-1), which fits unsigned.
    always_comb begin
        sample_u   = sample;
        abs_val    = sample_u[SAMPLE_WIDTH-1] ? (~sample_u + SAMPLE_WIDTH'(1)) : sample_u;
        acc_n      = acc + ACC_WIDTH'(abs_val);
        cnt_n      = cnt + 32'd1;
        limit_prod = PROD_WIDTH'(integ_thresh_avg) * PROD_WIDTH'(integ_window);
    end

    assign running = (state == ST_ARM) || (state == ST_RUN);

    // Control FSM, accumulator and sticky result registers.
    // The early trip (sum above limit) wins over window completion on the same sample.
    always_ff @(posedge spi_clk or posedge spi_rst) begin
        if (spi_rst) begin
            state       <= ST_IDLE;
            win         <= '0;
            cnt         <= '0;
            acc         <= '0;
            limit       <= '0;
            window_done <= 1'b0;
            over_thresh <= 1'b0;
            cfg_err     <= 1'b0;
            fault_sum   <= '0;
            fault_count <= '0;
        end else begin
            window_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (integ_en) begin
                        if (integ_window == 32'd0) begin
                            state   <= ST_FAULT;
                            cfg_err <= 1'b1;
                        end else begin
                            state <= ST_ARM;
                            win   <= integ_window;
                            limit <= ACC_WIDTH'(limit_prod);
                        end
                    end
                end
                ST_ARM: begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= integ_en ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (!integ_en) begin
                        state <= ST_IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (sample_valid) begin
                        if (acc_n > limit) begin
                            state       <= ST_FAULT;
                            over_thresh <= 1'b1;
                            fault_sum   <= acc_n;
                            fault_count <= cnt_n;
                        end else if (cnt_n == win) begin
                            window_done <= 1'b1;
                            acc         <= '0;
                            cnt         <= '0;
                        end else begin
                            acc <= acc_n;
                            cnt <= cnt_n;
                        end
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_integ_threshold_monitor.sv
// Scoreboard bench for integ_threshold_monitor: the driver updates a
// behavioural model and queues expected window/fault events; a monitor
// pops and compares whenever the DUT pulses window_done or raises over_thresh.
module tb_integ_threshold_monitor;

    logic               spi_clk = 1'b0;
    logic               spi_rst = 1'b1;
    logic               integ_en = 1'b0;
    logic [31:0]        integ_window = '0;
    logic [14:0]        integ_thresh_avg = '0;
    logic signed [15:0] sample = '0;
    logic               sample_valid = 1'b0;
    logic               running;
    logic               window_done;
    logic               over_thresh;
    logic               cfg_err;
    logic [47:0]        fault_sum;
    logic [31:0]        fault_count;

    integ_threshold_monitor #(.SAMPLE_WIDTH(16), .ACC_WIDTH(48)) dut (
        .spi_clk          (spi_clk),
        .spi_rst          (spi_rst),
        .integ_en         (integ_en),
        .integ_window     (integ_window),
        .integ_thresh_avg (integ_thresh_avg),
        .sample           (sample),
        .sample_valid     (sample_valid),
        .running          (running),
        .window_done      (window_done),
        .over_thresh      (over_thresh),
        .cfg_err          (cfg_err),
        .fault_sum        (fault_sum),
        .fault_count      (fault_count)
    );

    always #5 spi_clk = ~spi_clk;

    typedef struct {
        bit     is_fault;
        longint sum;
        longint count;
        int     cyc;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Reference model state (spec-level view)
    int          en_cycles = 0;   // consecutive enabled cycles since leaving idle
    bit          m_en = 0;
    bit          m_fault = 0;
    bit          m_cfg = 0;
    longint      m_win = 0;
    longint      m_limit = 0;
    longint      m_sum = 0;
    longint      m_n = 0;
    longint      m_fsum = 0;
    longint      m_fcnt = 0;
    logic [31:0] win_drv = '0;
    logic [14:0] thresh_drv = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge spi_clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and advance the model by what the DUT will see.
    task automatic step(input bit en, input bit v, input int s);
        longint a;
        @(negedge spi_clk);
        integ_en         = en;
        sample_valid     = v;
        sample           = 16'(s);
        integ_window     = win_drv;
        integ_thresh_avg = thresh_drv;
        m_en = en;
        if (!m_fault && !m_cfg) begin
            if (!en) begin
                en_cycles = 0;
            end else begin
                if (en_cycles == 0) begin
                    if (win_drv == 0) begin
                        m_cfg = 1;
                    end else begin
                        m_win   = longint'(win_drv);
                        m_limit = longint'(thresh_drv) * longint'(win_drv);
                        m_sum   = 0;
                        m_n     = 0;
                    end
                end else if (en_cycles >= 2 && v) begin
                    a = (s < 0) ? -longint'(s) : longint'(s);
                    m_sum += a;
                    m_n++;
                    if (m_sum > m_limit) begin
                        m_fault = 1;
                        m_fsum  = m_sum;
                        m_fcnt  = m_n;
                        q.push_back('{1'b1, m_sum, m_n, cyc + 1});
                    end else if (m_n == m_win) begin
                        q.push_back('{1'b0, 0, 0, cyc + 1});
                        m_sum = 0;
                        m_n   = 0;
                    end
                end
                en_cycles++;
            end
        end
    endtask

    task automatic arm(input int w, input int th);
        win_drv    = 32'(w);
        thresh_drv = 15'(th);
        step(1, 0, 0);
        step(1, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic apply_reset();
        @(negedge spi_clk);
        integ_en     = 0;
        sample_valid = 0;
        #2 spi_rst = 1;
        #1;
        chk("reset_outputs_zero",
            longint'(running) | longint'(window_done) | longint'(over_thresh) |
            longint'(cfg_err) | longint'(fault_sum) | longint'(fault_count), 0);
        @(negedge spi_clk);
        spi_rst   = 0;
        en_cycles = 0;
        m_en      = 0;
        m_fault   = 0;
        m_cfg     = 0;
        m_sum     = 0;
        m_n       = 0;
        q.delete();
    endtask

    task automatic check_state(input string tag);
        step(m_en, 0, 0);
        @(posedge spi_clk);
        #1;
        chk({tag, "_over_thresh"}, longint'(over_thresh), longint'(m_fault));
        chk({tag, "_cfg_err"}, longint'(cfg_err), longint'(m_cfg));
        chk({tag, "_running"}, longint'(running), longint'(m_en && !m_fault && !m_cfg));
        if (m_fault) begin
            chk({tag, "_fault_sum"}, longint'(fault_sum), m_fsum);
            chk({tag, "_fault_count"}, longint'(fault_count), m_fcnt);
        end
    endtask

    // Monitor: compares every DUT-presented event against the queue head.
    initial begin
        bit  prev_ot = 0;
        ev_t e;
        forever begin
            @(negedge spi_clk);
            if (spi_rst) begin
                prev_ot = 0;
            end else begin
                if (window_done) begin
                    if (q.size() == 0) chk("unexpected_window_done", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("event_kind_done", 0, longint'(e.is_fault));
                        chk("event_cycle_done", cyc, e.cyc);
                    end
                end
                if (over_thresh && !prev_ot) begin
                    if (q.size() == 0) chk("unexpected_over_thresh", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("event_kind_fault", 1, longint'(e.is_fault));
                        chk("event_cycle_fault", cyc, e.cyc);
                        chk("event_fault_sum", longint'(fault_sum), e.sum);
                        chk("event_fault_count", longint'(fault_count), e.count);
                    end
                end
                prev_ot = over_thresh;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, th, mag, s;
        bit en;
        apply_reset();

        // Arm, accept one sample, then reset mid-RUN
        arm(4, 100);
        check_state("arm");
        step(1, 1, 100);
        apply_reset();

        // Three clean windows at exactly the threshold average
        arm(4, 100);
        for (int i = 0; i < 12; i++) step(1, 1, (i % 2 == 0) ? 100 : -100);
        check_state("pass");

        // Early trip; later samples and enable toggling ignored
        apply_reset();
        arm(4, 100);
        step(1, 1, 300);
        step(1, 1, -150);
        step(1, 1, 500);
        step(0, 1, 20);
        step(1, 1, 20);
        check_state("trip");

        // Window 1, threshold 0
        apply_reset();
        arm(1, 0);
        step(1, 1, 0);
        step(1, 1, 1);
        check_state("thr0");

        // Most negative sample
        apply_reset();
        arm(1, 32767);
        step(1, 1, -32768);
        check_state("minneg");

        // Zero window
        apply_reset();
        win_drv = 0;
        step(1, 0, 0);
        step(1, 1, 5);
        check_state("win0");

        // Disable mid-window with simultaneous sample, re-enable with new threshold
        apply_reset();
        arm(8, 100);
        for (int i = 0; i < 3; i++) step(1, 1, 50);
        step(0, 1, 50);
        check_state("disable");
        arm(8, 10);
        step(1, 1, 50);
        step(1, 1, 40);
        check_state("rearm");

        // Threshold change during RUN is ignored
        apply_reset();
        arm(4, 100);
        step(1, 1, 100);
        step(1, 1, 100);
        thresh_drv = 1;
        for (int i = 0; i < 6; i++) step(1, 1, -100);
        check_state("cfgchg");

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            apply_reset();
            w  = $urandom_range(1, 6);
            th = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 32767) : $urandom_range(0, 150);
            arm(w, th);
            for (int i = 0; i < 24; i++) begin
                en = ($urandom_range(0, 19) != 0);
                if (!en && $urandom_range(0, 1) == 1) begin
                    win_drv    = ($urandom_range(0, 29) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
                    thresh_drv = 15'($urandom_range(0, 150));
                end
                if ($urandom_range(0, 9) == 0) thresh_drv = 15'($urandom_range(0, 150));
                if ($urandom_range(0, 24) == 0) s = -32768;
                else begin
                    mag = $urandom_range(0, 2 * int'(thresh_drv) + 5);
                    if (mag > 32767) mag = 32767;
                    s = ($urandom_range(0, 1) == 1) ? -mag : mag;
                end
                step(en, $urandom_range(0, 3) != 0, s);
            end
            check_state("rand");
        end

        step(m_en, 0, 0);
        step(m_en, 0, 0);
        @(posedge spi_clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
